// File: rtl/demux32_route.sv
// demux32_route: steers one producer stream into two independent
// per-destination FIFOs with delivered-word counters.
module demux32_route_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  input  logic             ready,
  output logic [CNT_W-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] OCC_ONE = 1;
  localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      occ;
  logic             pop;

  assign valid = (occ != '0);
  assign full  = (occ == OCC_FULL);
  assign pop   = valid & ready;
  assign dout  = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        count  <= count + CNT_ONE;
      end
      unique case (1'b1)
        (push & !pop): occ <= occ + OCC_ONE;
        (pop & !push): occ <= occ - OCC_ONE;
        default:       occ <= occ;
      endcase
    end
  end
endmodule

module demux32_route #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             sel,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_out,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_out,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count
);
  logic a_full;
  logic b_full;
  logic take;

  // ready depends only on sel and stored occupancy
  assign in_ready = !(sel ? b_full : a_full);
  assign take     = in_valid & in_ready;

  demux32_route_fifo #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) u_fifo_a (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (take & !sel),
    .wdata (in_data),
    .full  (a_full),
    .dout  (a_out),
    .valid (a_valid),
    .ready (a_ready),
    .count (a_count)
  );

  demux32_route_fifo #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) u_fifo_b (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (take & sel),
    .wdata (in_data),
    .full  (b_full),
    .dout  (b_out),
    .valid (b_valid),
    .ready (b_ready),
    .count (b_count)
  );
endmodule
